axil_kg_master: RTL and testbench

AXI4-Lite initiator that drives the Kugelblitz register-file slave from a simple command/response port. It accepts one single-beat read or write command at a time, issues it on the AXI4-Lite master interface, and returns the response (and read data) on a response port. It sits between control logic (or a debug/host bridge) and the Kugelblitz register-file slave on the same clock domain.

---
 rtl/axil_kg_master_if.sv | 43 ++++
 rtl/axil_kg_master.sv | 197 +++++++++++++++++++
 tb/tb_axil_kg_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_kg_master_if.sv
// AXI4-Lite channel bundle between the Kugelblitz initiator and its register-file slave.
interface axil_kg_master_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_kg_master.sv
// Single-outstanding AXI4-Lite initiator: command/response port in, AXI4-Lite master out.
// Define AXIL_KG_MASTER_READBACK_EN to follow every OKAY write with a compare read of the same address.
module axil_kg_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic                  cmd_write,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_mismatch,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  busy,
  axil_kg_master_if.master      m_axil
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RB_AR,
    S_RB_R,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_t;

  state_t state;

  assign m_axil.awprot = 3'b000;
  assign m_axil.arprot = 3'b000;

`ifdef AXIL_KG_MASTER_READBACK_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] byte_mask;

  // Expand the latched strobes to a bit mask so only written bytes are compared.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      byte_mask[i*8 +: 8] = {8{strb_q[i]}};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_resp       <= 2'b00;
      rsp_mismatch   <= 1'b0;
      m_axil.awaddr  <= '0;
      m_axil.awvalid <= 1'b0;
      m_axil.wdata   <= '0;
      m_axil.wstrb   <= '0;
      m_axil.wvalid  <= 1'b0;
      m_axil.bready  <= 1'b0;
      m_axil.araddr  <= '0;
      m_axil.arvalid <= 1'b0;
      m_axil.rready  <= 1'b0;
`ifdef AXIL_KG_MASTER_READBACK_EN
      addr_q         <= '0;
      data_q         <= '0;
      strb_q         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef AXIL_KG_MASTER_READBACK_EN
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            strb_q    <= cmd_strb;
`endif
            if (cmd_write) begin
              m_axil.awaddr  <= cmd_addr;
              m_axil.wdata   <= cmd_data;
              m_axil.wstrb   <= cmd_strb;
              m_axil.awvalid <= 1'b1;
              m_axil.wvalid  <= 1'b1;
              state          <= S_WR;
            end else begin
              m_axil.araddr  <= cmd_addr;
              m_axil.arvalid <= 1'b1;
              state          <= S_RD_AR;
            end
          end
        end

        // AW and W retire independently; a dropped valid marks its channel done.
        S_WR: begin
          if (m_axil.awready) m_axil.awvalid <= 1'b0;
          if (m_axil.wready)  m_axil.wvalid  <= 1'b0;
          if ((!m_axil.awvalid || m_axil.awready) && (!m_axil.wvalid || m_axil.wready)) begin
            m_axil.bready <= 1'b1;
            state         <= S_WB;
          end
        end

        S_WB: begin
          if (m_axil.bvalid) begin
            m_axil.bready <= 1'b0;
`ifdef AXIL_KG_MASTER_READBACK_EN
            if (m_axil.bresp == 2'b00) begin
              m_axil.araddr  <= addr_q;
              m_axil.arvalid <= 1'b1;
              state          <= S_RB_AR;
            end else begin
              rsp_resp  <= m_axil.bresp;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= S_RSP;
            end
`else
            rsp_resp  <= m_axil.bresp;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
`endif
          end
        end

`ifdef AXIL_KG_MASTER_READBACK_EN
        S_RB_AR: begin
          if (m_axil.arready) begin
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b1;
            state          <= S_RB_R;
          end
        end

        // bresp was OKAY to get here, so the read response decides rsp_resp.
        S_RB_R: begin
          if (m_axil.rvalid) begin
            m_axil.rready <= 1'b0;
            rsp_data      <= m_axil.rdata;
            rsp_resp      <= m_axil.rresp;
            rsp_mismatch  <= |((m_axil.rdata ^ data_q) & byte_mask);
            rsp_valid     <= 1'b1;
            state         <= S_RSP;
          end
        end
`endif

        S_RD_AR: begin
          if (m_axil.arready) begin
            m_axil.arvalid <= 1'b0;
            m_axil.rready  <= 1'b1;
            state          <= S_RD_R;
          end
        end

        S_RD_R: begin
          if (m_axil.rvalid) begin
            m_axil.rready <= 1'b0;
            rsp_data      <= m_axil.rdata;
            rsp_resp      <= m_axil.rresp;
            rsp_valid     <= 1'b1;
            state         <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_resp     <= 2'b00;
            rsp_mismatch <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_kg_master.sv
// Directed bench for axil_kg_master with a response scoreboard and a small AXI4-Lite slave model.
// Readback-specific steps compile in when AXIL_KG_MASTER_READBACK_EN is defined.
module tb_axil_kg_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = DW / 8;
`ifdef AXIL_KG_MASTER_READBACK_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          cmd_write = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          rsp_mismatch;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          busy;

  always #5 clk = ~clk;

  axil_kg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

  axil_kg_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .cmd_write(cmd_write), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
    .m_axil(axil)
  );

  // Slave model: AW/AR always ready, W gated by w_block, B/R one cycle after the handshake.
  logic          w_block = 1'b0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  logic          aw_pend, w_pend;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  logic [AW-1:0] last_awaddr, last_araddr;
  logic [DW-1:0] last_wdata;
  logic [SW-1:0] last_wstrb;
  logic          aw_hs, w_hs, ar_hs;

  assign axil.awready = 1'b1;
  assign axil.arready = 1'b1;
  assign axil.wready  = !w_block;
  assign aw_hs = axil.awvalid && axil.awready;
  assign w_hs  = axil.wvalid && axil.wready;
  assign ar_hs = axil.arvalid && axil.arready;

  always @(posedge clk) begin
    if (rst) begin
      axil.bvalid <= 1'b0;
      axil.bresp  <= 2'b00;
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
      axil.rresp  <= 2'b00;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
    end else begin
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; last_awaddr <= axil.awaddr; end
      if (w_hs) begin w_cnt <= w_cnt + 1; last_wdata <= axil.wdata; last_wstrb <= axil.wstrb; end
      if (axil.bvalid && axil.bready) begin axil.bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if ((aw_pend || aw_hs) && (w_pend || w_hs)) begin
        axil.bvalid <= 1'b1;
        axil.bresp  <= bresp_cfg;
        aw_pend     <= 1'b0;
        w_pend      <= 1'b0;
      end else begin
        if (aw_hs) aw_pend <= 1'b1;
        if (w_hs)  w_pend  <= 1'b1;
      end
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
      if (ar_hs) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= rdata_cfg;
        axil.rresp  <= rresp_cfg;
        ar_cnt      <= ar_cnt + 1;
        last_araddr <= axil.araddr;
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          mism;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed unexpected response data 0x%0h expected none", rsp_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_resp", 32'(rsp_resp), 32'(mon_e.resp));
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(mon_e.mism));
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] r, input logic m);
    exp_t e;
    e.data = d;
    e.resp = r;
    e.mism = m;
    sb.push_back(e);
  endtask

  // Returns one cycle after the accepting edge (cycle N+1).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_sb"}, 32'(sb.size()), 0);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_awvalid"}, 32'(axil.awvalid), 0);
    check({p, "_wvalid"}, 32'(axil.wvalid), 0);
    check({p, "_bready"}, 32'(axil.bready), 0);
    check({p, "_arvalid"}, 32'(axil.arvalid), 0);
    check({p, "_rready"}, 32'(axil.rready), 0);
    check({p, "_awaddr"}, 32'(axil.awaddr), 0);
    check({p, "_wdata"}, axil.wdata, 0);
    check({p, "_araddr"}, 32'(axil.araddr), 0);
    check({p, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({p, "_rsp_data"}, rsp_data, 0);
    check({p, "_rsp_resp"}, 32'(rsp_resp), 0);
    check({p, "_rsp_mismatch"}, 32'(rsp_mismatch), 0);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  function automatic logic [DW-1:0] wr_rsp_data(input logic [DW-1:0] rb);
`ifdef AXIL_KG_MASTER_READBACK_EN
    return rb;
`else
    return (rb & 32'h0);
`endif
  endfunction

  int b0, ar0, aw0, w0;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", 32'(cmd_ready), 1);

    // Plain write, always-ready slave
    rdata_cfg = 32'hDEADBEEF;
    aw0 = aw_cnt; w0 = w_cnt;
    push_exp(wr_rsp_data(32'hDEADBEEF), 2'b00, 1'b0);
    issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    check("wr_awvalid_n1", 32'(axil.awvalid), 1);
    check("wr_wvalid_n1", 32'(axil.wvalid), 1);
    check("wr_awaddr", 32'(axil.awaddr), 32'h0004);
    check("wr_wdata", axil.wdata, 32'hDEADBEEF);
    check("wr_cmd_ready_busy", 32'(cmd_ready), 0);
    repeat (WR_LAT - 2) begin @(posedge clk); #1; end
    check("wr_rsp_valid_early", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("wr_rsp_valid_lat", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    check("wr_busy_after_rsp", 32'(busy), 0);
    check("wr_cmd_ready_after_rsp", 32'(cmd_ready), 1);
    wait_idle("wr");
    check("wr_aw_count", 32'(aw_cnt - aw0), 1);
    check("wr_w_count", 32'(w_cnt - w0), 1);
    check("wr_last_wstrb", 32'(last_wstrb), 32'hF);

    // Read
    rdata_cfg = 32'h12345678;
    push_exp(32'h12345678, 2'b00, 1'b0);
    issue(1'b0, 16'h0008, 32'h0, 4'h0);
    check("rd_arvalid_n1", 32'(axil.arvalid), 1);
    check("rd_araddr", 32'(axil.araddr), 32'h0008);
    check("rd_awvalid_quiet", 32'(axil.awvalid), 0);
    @(posedge clk); #1;
    check("rd_rsp_valid_early", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("rd_rsp_valid_lat", 32'(rsp_valid), 1);
    wait_idle("rd");

    // Read with SLVERR
    rdata_cfg = 32'h55AA00FF;
    rresp_cfg = 2'b10;
    push_exp(32'h55AA00FF, 2'b10, 1'b0);
    issue(1'b0, 16'h000C, 32'h0, 4'h0);
    wait_idle("rd_err");
    rresp_cfg = 2'b00;

    // Write with wready delayed 3 cycles after the AW handshake
    rdata_cfg = 32'h0BEEF123;
    b0 = b_cnt;
    w_block = 1'b1;
    push_exp(wr_rsp_data(32'h0BEEF123), 2'b00, 1'b0);
    issue(1'b1, 16'h0020, 32'h0BEEF123, 4'hF);
    check("slow_w_awvalid_n1", 32'(axil.awvalid), 1);
    @(posedge clk); #1;
    check("slow_w_awvalid_dropped", 32'(axil.awvalid), 0);
    check("slow_w_wvalid_held1", 32'(axil.wvalid), 1);
    repeat (2) begin @(posedge clk); #1; end
    check("slow_w_wvalid_held3", 32'(axil.wvalid), 1);
    check("slow_w_no_b_yet", 32'(b_cnt - b0), 0);
    w_block = 1'b0;
    wait_idle("slow_w");
    check("slow_w_one_b", 32'(b_cnt - b0), 1);
    check("slow_w_wdata", last_wdata, 32'h0BEEF123);

    // Write answered with SLVERR: no readback read
    ar0 = ar_cnt;
    bresp_cfg = 2'b10;
    rdata_cfg = 32'h11111111;
    push_exp(32'h0, 2'b10, 1'b0);
    issue(1'b1, 16'h0030, 32'h11111111, 4'hF);
    wait_idle("berr");
    check("berr_no_ar", 32'(ar_cnt - ar0), 0);
    bresp_cfg = 2'b00;

`ifdef AXIL_KG_MASTER_READBACK_EN
    // Readback compare restricted to strobed bytes
    rdata_cfg = 32'h0000CCDD;
    push_exp(32'h0000CCDD, 2'b00, 1'b0);
    issue(1'b1, 16'h0040, 32'hAABBCCDD, 4'b0011);
    wait_idle("rb_match");
    check("rb_araddr", 32'(last_araddr), 32'h0040);
    rdata_cfg = 32'h0000CC00;
    push_exp(32'h0000CC00, 2'b00, 1'b0 | 1'b1);
    issue(1'b1, 16'h0040, 32'hAABBCCDD, 4'b0011);
    wait_idle("rb_mismatch");
`endif

    // Stall rsp_ready in RSP, then reset mid-response
    rsp_ready = 1'b0;
    rdata_cfg = 32'hCAFEF00D;
    push_exp(32'hCAFEF00D, 2'b00, 1'b0);
    issue(1'b0, 16'h0050, 32'h0, 4'h0);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    check("stall_rsp_valid", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid_hold", 32'(rsp_valid), 1);
      check("stall_rsp_data_hold", rsp_data, 32'hCAFEF00D);
      check("stall_rsp_resp_hold", 32'(rsp_resp), 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    sb.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_rst");

    // Recovery read
    rdata_cfg = 32'h0BADF00D;
    push_exp(32'h0BADF00D, 2'b00, 1'b0);
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_idle("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
